// File: rtl/systolic_matmul.sv
// Output-stationary N x N systolic matrix multiplier: C = A(NxK) * B(KxN).
// Columns of A enter from the left and rows of B from the top. Each PE
// accumulates its own C element, and c_out exposes the accumulators directly.
module systolic_matmul #(
   parameter int N    = 2,
   parameter int DW   = 8,
   parameter int KW   = 8,
   parameter int ACCW = 2*DW+KW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   input  logic              signed_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N*DW-1:0]   a_col,
   input  logic [N*DW-1:0]   b_row,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N*N*ACCW-1:0] c_out
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   localparam int DCW = $clog2(2*N) + 1;

   state_t         state;
   logic [KW-1:0]  k_q;
   logic [KW-1:0]  beat_cnt;
   logic [DCW-1:0] drain_cnt;
   logic           signed_q;

   logic accept;
   logic clr;
   logic acc_en;

   logic [DW-1:0] inj_a [N];
   logic [DW-1:0] inj_b [N];

   // a_h[i][j]: A operand entering PE(i,j); b_v[i][j]: B operand entering PE(i,j)
   logic [N-1:0][N-1:0][DW-1:0] a_h;
   logic [N-1:0][N-1:0][DW-1:0] b_v;

   assign accept = (state == LOAD) && in_valid;
   assign clr    = rst || ((state == IDLE) && start);
   assign acc_en = (state == LOAD) || (state == DRAIN);

   // Control FSM: job setup, beat counting, drain timing and result handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k_q       <= '0;
         signed_q  <= 1'b0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  k_q       <= k_len;
                  signed_q  <= signed_en;
                  beat_cnt  <= '0;
                  drain_cnt <= '0;
                  busy      <= 1'b1;
                  if (k_len == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  if (beat_cnt == k_q - KW'(1)) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + KW'(1);
                  end
               end
            end
            DRAIN: begin
               // The last beat reaches PE(N-1,N-1) 2N-2 edges after acceptance.
               // out_valid is raised 2N edges after that acceptance.
               if (drain_cnt == DCW'(2*N-1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  drain_cnt <= '0;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand injection: an accepted beat enters the array, any other cycle injects zeros
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         inj_a[i] = accept ? a_col[i*DW +: DW] : '0;
         inj_b[i] = accept ? b_row[i*DW +: DW] : '0;
      end
   end

   // Input skew: A row i and B column i are each delayed by i cycles
   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_h[0][0] = inj_a[0];
         assign b_v[0][0] = inj_b[0];
      end else begin : g_delay
         logic [DW-1:0] a_sr [i];
         logic [DW-1:0] b_sr [i];

         // Shift registers of depth i, cleared when a job starts
         always_ff @(posedge clk) begin
            if (clr) begin
               for (int unsigned d = 0; d < i; d++) begin
                  a_sr[d] <= '0;
                  b_sr[d] <= '0;
               end
            end else begin
               a_sr[0] <= inj_a[i];
               b_sr[0] <= inj_b[i];
               for (int unsigned d = 1; d < i; d++) begin
                  a_sr[d] <= a_sr[d-1];
                  b_sr[d] <= b_sr[d-1];
               end
            end
         end

         assign a_h[i][0] = a_sr[i-1];
         assign b_v[0][i] = b_sr[i-1];
      end
   end

   // Processing elements
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [DW-1:0]          a_in;
         logic [DW-1:0]          b_in;
         logic [2*DW-1:0]        prod_u;
         logic signed [2*DW-1:0] prod_s;
         logic [ACCW-1:0]        prod_x;
         logic [ACCW-1:0]        acc_r;

         assign a_in   = a_h[i][j];
         assign b_in   = b_v[i][j];
         assign prod_u = a_in * b_in;
         assign prod_s = $signed(a_in) * $signed(b_in);
         assign prod_x = signed_q ? ACCW'(prod_s) : ACCW'(prod_u);

         // Accumulate the local product while operands are flowing (wraps modulo 2^ACCW)
         always_ff @(posedge clk) begin
            if (clr) begin
               acc_r <= '0;
            end else if (acc_en) begin
               acc_r <= acc_r + prod_x;
            end
         end

         assign c_out[(i*N+j)*ACCW +: ACCW] = acc_r;

         if (j < N-1) begin : g_a_pass
            logic [DW-1:0] a_r;
            // Forward A one hop to the right
            always_ff @(posedge clk) begin
               if (clr) a_r <= '0;
               else     a_r <= a_in;
            end
            assign a_h[i][j+1] = a_r;
         end

         if (i < N-1) begin : g_b_pass
            logic [DW-1:0] b_r;
            // Forward B one hop downward
            always_ff @(posedge clk) begin
               if (clr) b_r <= '0;
               else     b_r <= b_in;
            end
            assign b_v[i+1][j] = b_r;
         end
      end
   end

endmodule
